buzzer_sequencer: RTL and testbench



---
 rtl/buzzer_sequencer_if.sv | 38 +++
 rtl/buzzer_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_sequencer_if.sv
//==============================================================================
// Module      : buzzer_sequencer_if
// Description : CPU-side push/flush bus plus the Buzzer16 command strobe of the
//               buzzer note sequencer, bundled with master/slave views.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface buzzer_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 12
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic               wr;
    logic [DUR_W+7:0]   wdata;
    logic               clear;
    logic               full;
    logic [LVL_W-1:0]   level;
    logic               busy;
    logic               done;
    logic [23:0]        cmd_out;
    logic               cmd_valid;

    // Requester side: pushes note records and may flush the queue.
    modport master (
        output wr, wdata, clear,
        input  full, level, busy, done, cmd_out, cmd_valid
    );

    // Sequencer side.
    modport slave (
        input  wr, wdata, clear,
        output full, level, busy, done, cmd_out, cmd_valid
    );
endinterface

`default_nettype wire

// File: rtl/buzzer_sequencer.sv
//==============================================================================
// Module      : buzzer_sequencer
// Description : Note-queue controller for the Buzzer16 tone block. Buffers
//               {dur, vol, note} records in a FIFO and issues VOL/SET/STOP
//               command words, holding each note for dur ticks of TICK_DIV
//               clk cycles. Optional macro BUZZSEQ_LOOP_EN adds a `loop`
//               input that recirculates popped records to replay the tune.
//               TICK_DIV must be at least 2.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module buzzer_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 12
) (
    input  wire logic           clk,
    input  wire logic           rst,
`ifdef BUZZSEQ_LOOP_EN
    input  wire logic           loop,
`endif
    buzzer_sequencer_if.slave   bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int REC_W = DUR_W + 8;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] OP_SET  = 8'd1;
    localparam logic [7:0] OP_STOP = 8'd2;
    localparam logic [7:0] OP_VOL  = 8'd3;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    // The NOTEC cycle is cycle 0 of the first tick, so HOLD starts at 1 and
    // the note lasts exactly dur*TICK_DIV cycles from NOTEC to the exit.
    localparam logic [PRE_W-1:0] PRE_START = (TICK_DIV > 1) ? PRE_W'(1) : '0;
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VOLC  = 3'd1,
        S_NOTEC = 3'd2,
        S_HOLD  = 3'd3,
        S_STOPC = 3'd4
    } state_t;

    // ---------------------------------------------------------------- state
    state_t             state_q, state_d;

    // ----------------------------------------------------------------- FIFO
    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [LVL_W-1:0]   count_q;

    // ------------------------------------------------------------- datapath
    logic [DUR_W-1:0]   cur_dur_q,   cur_dur_d;
    logic [1:0]         cur_vol_q,   cur_vol_d;
    logic [5:0]         cur_note_q,  cur_note_d;
    logic [1:0]         last_vol_q,  last_vol_d;
    logic               vol_known_q, vol_known_d;
    logic [DUR_W-1:0]   dcnt_q,      dcnt_d;
    logic [PRE_W-1:0]   pre_q,       pre_d;
    logic [23:0]        cmd_q,       cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               done_q,      done_d;

    // ------------------------------------------------------------- controls
    logic               loop_act;
    logic               fifo_empty;
    logic               fifo_full;
    logic [REC_W-1:0]   head;
    logic               pop;
    logic               push_ext;
    logic               push_rep;
    logic               push;
    logic [REC_W-1:0]   push_data;
    logic               tick_wrap;

`ifdef BUZZSEQ_LOOP_EN
    assign loop_act = loop;
`else
    assign loop_act = 1'b0;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LVL_FULL);
    assign head       = mem_q[rd_ptr_q];
    assign tick_wrap  = (pre_q == PRE_LAST);

    // A full FIFO still accepts a push when a pop frees a slot in the same
    // cycle. In loop mode the popped record is re-pushed instead, and
    // external writes are ignored so the recirculating tune stays intact.
    assign push_ext  = bus.wr && !bus.clear && !loop_act && (!fifo_full || pop);
    assign push_rep  = pop && loop_act;
    assign push      = push_ext || push_rep;
    assign push_data = push_rep ? head : bus.wdata;

    assign bus.full      = fifo_full;
    assign bus.level     = count_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.cmd_out   = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;

    // FIFO storage: data words carry no reset, only pointers/occupancy do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // FIFO pointers and occupancy; clear empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pop decision and command generation.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cur_dur_d   = cur_dur_q;
        cur_vol_d   = cur_vol_q;
        cur_note_d  = cur_note_q;
        last_vol_d  = last_vol_q;
        vol_known_d = vol_known_q;
        dcnt_d      = dcnt_q;
        pre_d       = pre_q;
        cmd_d       = 24'h0;
        cmd_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A flush in IDLE leaves the sequencer idle.
                if (!bus.clear && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_VOLC;
                end
            end

            S_VOLC: begin
                if (bus.clear) begin
                    state_d = S_STOPC;
                end else begin
                    // Only re-send volume when it actually changes.
                    if (!vol_known_q || (cur_vol_q != last_vol_q)) begin
                        cmd_d       = {OP_VOL, 14'd0, cur_vol_q};
                        cmd_valid_d = 1'b1;
                        last_vol_d  = cur_vol_q;
                        vol_known_d = 1'b1;
                    end
                    state_d = S_NOTEC;
                end
            end

            S_NOTEC: begin
                if (bus.clear) begin
                    state_d = S_STOPC;
                end else begin
                    // Note 0 is a rest: silence the buzzer for its duration.
                    if (cur_note_q == 6'd0) begin
                        cmd_d = {OP_STOP, 16'd0};
                    end else begin
                        cmd_d = {OP_SET, 10'd0, cur_note_q};
                    end
                    cmd_valid_d = 1'b1;
                    dcnt_d      = (cur_dur_q == '0) ? DUR_ONE : cur_dur_q;
                    pre_d       = PRE_START;
                    state_d     = S_HOLD;
                end
            end

            S_HOLD: begin
                if (bus.clear) begin
                    state_d = S_STOPC;
                end else begin
                    pre_d = tick_wrap ? '0 : pre_q + 1'b1;
                    if (tick_wrap) begin
                        dcnt_d = dcnt_q - 1'b1;
                        if (dcnt_q == DUR_ONE) begin
                            // Legato: the next note follows without a STOP.
                            if (!fifo_empty) begin
                                pop     = 1'b1;
                                state_d = S_VOLC;
                            end else begin
                                state_d = S_STOPC;
                            end
                        end
                    end
                end
            end

            S_STOPC: begin
                cmd_d       = {OP_STOP, 16'd0};
                cmd_valid_d = 1'b1;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            cur_dur_d  = head[REC_W-1:8];
            cur_vol_d  = head[7:6];
            cur_note_d = head[5:0];
        end
    end

    // Current record, volume cache, tick counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_dur_q   <= '0;
            cur_vol_q   <= '0;
            cur_note_q  <= '0;
            last_vol_q  <= '0;
            vol_known_q <= 1'b0;
            dcnt_q      <= '0;
            pre_q       <= '0;
            cmd_q       <= 24'h0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cur_dur_q   <= cur_dur_d;
            cur_vol_q   <= cur_vol_d;
            cur_note_q  <= cur_note_d;
            last_vol_q  <= last_vol_d;
            vol_known_q <= vol_known_d;
            dcnt_q      <= dcnt_d;
            pre_q       <= pre_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_buzzer_sequencer.sv
//==============================================================================
// Module      : tb_buzzer_sequencer
// Description : Self-checking bench for buzzer_sequencer (DEPTH=4, TICK_DIV=4,
//               DUR_W=12). Expected command words are queued as notes are
//               pushed and matched against the command strobe as it fires.
//               Macro BUZZSEQ_LOOP_EN enables the loop-mode scenario.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_buzzer_sequencer;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int DUR_W    = 12;

    localparam logic [23:0] C_STOP = 24'h020000;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef BUZZSEQ_LOOP_EN
    logic loop = 1'b0;
`endif

    buzzer_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    buzzer_sequencer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .DUR_W    (DUR_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef BUZZSEQ_LOOP_EN
        .loop (loop),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] cmd;
        logic        done;
        int          gap;   // cycles since previous command, -1 = don't care
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cmd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input logic [23:0] c, input logic d, input int g);
        exp_t e;
        e.cmd  = c;
        e.done = d;
        e.gap  = g;
        sb.push_back(e);
    endtask

    function automatic logic [19:0] rec(input int dur, input int vol, input int note);
        return {12'(dur), 2'(vol), 6'(note)};
    endfunction

    // Drive one push across a single rising edge; returns 1 time unit after it.
    task automatic push(input logic [19:0] d);
        bus.wr    = 1'b1;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wr    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for all expected commands and for the sequencer to idle.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drained"}, sb.size(), 0);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    // Command monitor: every strobe must match the scoreboard head, and the
    // bus must carry NOP with no done pulse whenever the strobe is low.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd", 32'(bus.cmd_out), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("cmd_word", 32'(bus.cmd_out), 32'(mon_e.cmd));
                    chk("done_with_cmd", 32'(bus.done), 32'(mon_e.done));
                    if (mon_e.gap >= 0) begin
                        chk("cmd_gap", cyc - last_cmd_cyc, mon_e.gap);
                    end
                end
                last_cmd_cyc = cyc;
            end else begin
                chk("nop_when_idle", 32'(bus.cmd_out), 32'h0);
                chk("done_without_cmd", 32'(bus.done), 32'h0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lvl_exp [6];
        int full_exp [6];
        lvl_exp  = '{1, 1, 2, 3, 4, 4};
        full_exp = '{0, 0, 0, 0, 1, 1};

        bus.wr    = 1'b0;
        bus.wdata = '0;
        bus.clear = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_out", 32'(bus.cmd_out), 0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_full", 32'(bus.full), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single note, VOL then SET, STOP 12 cycles after SET
        expect_cmd(24'h030002, 1'b0, -1);
        expect_cmd(24'h01000A, 1'b0, 1);
        expect_cmd(C_STOP,     1'b1, 12);
        @(negedge clk);
        push(rec(3, 2, 10));
        chk("t1_level_after_push", 32'(bus.level), 1);
        chk("t1_busy_not_yet", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("t1_busy_after_pop", 32'(bus.busy), 1);
        chk("t1_level_after_pop", 32'(bus.level), 0);
        drain("t1");

        // 2: two notes same volume, legato, single VOL and single STOP
        do_reset();
        expect_cmd(24'h030002, 1'b0, -1);
        expect_cmd(24'h01000A, 1'b0, 1);
        expect_cmd(24'h010014, 1'b0, 9);
        expect_cmd(C_STOP,     1'b1, 8);
        push(rec(2, 2, 10));
        push(rec(2, 2, 20));
        drain("t2");

        // 3: six back-to-back pushes; first pop overlaps the 2nd push,
        //    the 6th finds the FIFO full and is dropped
        expect_cmd(24'h030001, 1'b0, -1);
        expect_cmd(24'h010001, 1'b0, 1);
        for (int i = 2; i <= 5; i++) begin
            expect_cmd(24'h010000 | 24'(i), 1'b0, 5);
        end
        expect_cmd(C_STOP, 1'b1, 4);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            push(rec(1, 1, i + 1));
            chk($sformatf("t3_level_%0d", i), 32'(bus.level), 32'(lvl_exp[i]));
            chk($sformatf("t3_full_%0d", i), 32'(bus.full), 32'(full_exp[i]));
        end
        drain("t3");

        // 4: rest with zero duration: STOP at NOTEC, one tick, STOP + done
        expect_cmd(C_STOP, 1'b0, -1);
        expect_cmd(C_STOP, 1'b1, 4);
        @(negedge clk);
        push(rec(0, 1, 0));
        drain("t4");

        // 5: clear during a long HOLD with two records queued
        expect_cmd(24'h030003, 1'b0, -1);
        expect_cmd(24'h010005, 1'b0, 1);
        @(negedge clk);
        push(rec(100, 3, 5));
        push(rec(1, 3, 6));
        push(rec(1, 3, 7));
        chk("t5_level_queued", 32'(bus.level), 2);
        repeat (20) @(negedge clk);
        expect_cmd(C_STOP, 1'b1, -1);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        chk("t5_level_cleared", 32'(bus.level), 0);
        chk("t5_busy_stopc", 32'(bus.busy), 1);
        @(posedge clk);
        #1;
        chk("t5_stop_word", 32'(bus.cmd_out), 32'(C_STOP));
        chk("t5_busy_after", 32'(bus.busy), 0);
        chk("t5_level_after", 32'(bus.level), 0);
        drain("t5");

`ifdef BUZZSEQ_LOOP_EN
        // 6: loop mode replays A,B; dropping loop gives one more A,B then STOP
        begin
            int nb;
            int n;
            expect_cmd(24'h010009, 1'b0, -1);
            expect_cmd(24'h010007, 1'b0, 13);
            for (int i = 0; i < 3; i++) begin
                expect_cmd(24'h010008, 1'b0, 5);
                expect_cmd(24'h010007, 1'b0, 5);
            end
            expect_cmd(24'h010008, 1'b0, 5);
            expect_cmd(C_STOP,     1'b1, 4);
            @(negedge clk);
            push(rec(3, 3, 9));
            push(rec(1, 3, 7));
            push(rec(1, 3, 8));
            loop = 1'b1;
            chk("t6_level_start", 32'(bus.level), 2);
            push(rec(1, 3, 30));
            chk("t6_wr_ignored", 32'(bus.level), 2);
            nb = 0;
            n  = 0;
            while (nb < 2 && n < 500) begin
                @(negedge clk);
                n++;
                if (bus.cmd_valid && bus.cmd_out == 24'h010008) nb++;
            end
            chk("t6_b_seen", nb, 2);
            chk("t6_level_loop", 32'(bus.level), 2);
            loop = 1'b0;
            drain("t6");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
